// File: rtl/step_pulse_gen_pkg.sv
// Shared types and defaults for the single-step pulse source.
// Sizing helpers keep counter widths tied to the parameters they must hold.
package step_pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } step_state_e;

    localparam int DEF_DB_CYCLES  = 16;
    localparam int DEF_PULSE_W    = 5;
    localparam int DEF_GAP_CYCLES = 200;
    localparam int DEF_CNT_W      = 6;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..maxVal, never less than one bit.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/step_pulse_gen_btn_debounce.sv
// Two-flop synchroniser plus stable-level debounce for a bouncy board button.
// level_o only changes after DB_CYCLES consecutive cycles of disagreement.
module btn_debounce
    import step_pulse_gen_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o
);

    localparam int DB_W = cntWidth(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            dbLevel_q;
    logic            dbLevel_d;
    logic [DB_W-1:0] dbCnt_q;
    logic [DB_W-1:0] dbCnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            dbLevel_q <= 1'b0;
            dbCnt_q   <= '0;
        end else begin
            sync1_q   <= btn_i;
            sync2_q   <= sync1_q;
            dbLevel_q <= dbLevel_d;
            dbCnt_q   <= dbCnt_d;
        end
    end

    // Any cycle of agreement restarts the count, so short bounces never accumulate.
    always_comb begin
        dbCnt_d   = dbCnt_q;
        dbLevel_d = dbLevel_q;
        if (sync2_q == dbLevel_q) begin
            dbCnt_d = '0;
        end else if (dbCnt_q == CNT_MAX) begin
            dbLevel_d = ~dbLevel_q;
            dbCnt_d   = '0;
        end else begin
            dbCnt_d = dbCnt_q + 1'b1;
        end
    end

    assign level_o = dbLevel_q;

endmodule

// File: rtl/step_pulse_gen.sv
// Single-step clock source: debounced press or free-run request becomes a
// fixed-width PCclk pulse followed by a guard gap, with a wrapping step count.
module step_pulse_gen
    import step_pulse_gen_pkg::*;
#(
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter int PULSE_W    = DEF_PULSE_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    input  logic             run_en,
    output logic             PCclk,
    output logic             busy,
    output logic [CNT_W-1:0] step_count
);

    localparam int TMR_W = cntWidth(maxOf(PULSE_W, GAP_CYCLES) - 1);
    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_W - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);

    logic             dbLevel;
    logic             dbPrev_q;
    logic             pressEvent;

    step_state_e      state_q;
    step_state_e      state_d;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic             pcClk_q;
    logic             pcClk_d;
    logic             busy_q;
    logic             busy_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_raw),
        .level_o(dbLevel)
    );

    assign pressEvent = dbLevel & ~dbPrev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dbPrev_q <= 1'b0;
            state_q  <= IDLE;
            timer_q  <= '0;
            pcClk_q  <= 1'b0;
            busy_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            dbPrev_q <= dbLevel;
            state_q  <= state_d;
            timer_q  <= timer_d;
            pcClk_q  <= pcClk_d;
            busy_q   <= busy_d;
            count_q  <= count_d;
        end
    end

    // Presses are only consumed in IDLE; anything arriving while busy is dropped.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pcClk_d = pcClk_q;
        busy_d  = busy_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (run_en || pressEvent) begin
                    state_d = PULSE;
                    timer_d = PULSE_LOAD;
                    pcClk_d = 1'b1;
                    busy_d  = 1'b1;
                    count_d = count_q + 1'b1;
                end
            end
            PULSE: begin
                if (timer_q == '0) begin
                    state_d = GAP;
                    timer_d = GAP_LOAD;
                    pcClk_d = 1'b0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            GAP: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                pcClk_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign PCclk      = pcClk_q;
    assign busy       = busy_q;
    assign step_count = count_q;

endmodule

// File: doc/step_pulse_gen.md
Name: step_pulse_gen

Overview:
Source side of the single-step clock path. Turns the raw step button (or a free-run request) into clean, fixed-width PCclk pulses for the downstream delay/phase generator. Enforces a guard gap after each pulse so the downstream delay chain finishes all 10 taps before the next pulse. Keeps a wrap-around count of issued steps for the debug display.

Parameters:
DB_CYCLES, 16, consecutive stable cycles required to accept a new debounced level (>=1)
PULSE_W, 5, PCclk high width in clk cycles (>=1)
GAP_CYCLES, 200, PCclk low cycles enforced after each pulse before the next can start (>=1)
CNT_W, 6, width of step_count

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  synchronous, active-high reset
btn_raw  in  1  raw asynchronous step button, active-high, bouncy
run_en  in  1  free-run mode enable (level, synchronous to clk)
PCclk  out  1  registered step pulse to the delay block
busy  out  1  high while in PULSE or GAP
step_count  out  CNT_W  number of pulses issued, mod 2^CNT_W

Behaviour:
- Reset (rst=1 at an edge): sync flops=0, db_level=0, db counter=0, state=IDLE, PCclk=0, busy=0, step_count=0. Reset wins over all events. A pulse or gap in progress is aborted, and PCclk is 0 after that edge.
- Synchroniser: 2 flops on btn_raw (sync1, sync2).
- Debounce: counter increments each cycle that sync2 != db_level and clears when they are equal. When the counter reaches DB_CYCLES-1 while still differing, db_level toggles and the counter clears. Any bounce shorter than DB_CYCLES is rejected.
- Press event: db_level 0->1, detected with a registered db_prev. Release produces no event. A new press requires a full debounced release first.
- FSM states: IDLE, PULSE, GAP.
  - IDLE -> PULSE when (press event & !run_en) or run_en. On that edge: PCclk<=1, step_count<=step_count+1 (wraps 2^CNT_W-1 -> 0), width counter loaded.
  - PULSE: PCclk stays 1 for exactly PULSE_W cycles, then -> GAP with PCclk<=0.
  - GAP: PCclk stays 0 for exactly GAP_CYCLES cycles, then -> IDLE.
  - busy = (state != IDLE), registered together with the state.
- Latency: count the edge that first samples btn_raw=1 as edge 0. With btn_raw held clean, PCclk is first high after edge DB_CYCLES+2.
- Presses during PULSE or GAP are dropped: no queueing, no count change.
- Press debounced on the same edge the FSM returns to IDLE: not seen, because the event is consumed only in IDLE.
- Free-run: with run_en=1, pulses repeat with period PULSE_W+GAP_CYCLES+1, and the button is ignored. Deasserting run_en mid-pulse lets the current PULSE and GAP complete, then the FSM stays in IDLE.
- PCclk never glitches: it is driven only from the state register.

Decomposition:
- Shared package: FSM state enum (IDLE/PULSE/GAP), default constants for DB_CYCLES, PULSE_W, GAP_CYCLES, CNT_W.
- One natural sub-module: btn_debounce (synchroniser + debounce counter + db_level output), reusable for other board buttons.
- FSM and counters stay in step_pulse_gen.

Test Plan:
(Bench parameters: DB_CYCLES=4, PULSE_W=5, GAP_CYCLES=20; half-period 1 ns.)
1. Clean press: btn_raw 0->1 held 30 cycles -> PCclk rises after edge 6, high exactly 5 cycles, busy high 25 cycles, step_count=1.
2. Bounce: btn_raw toggles with 1-2 cycle widths for 10 cycles, then stays high -> exactly one pulse, step_count=1. Bounces shorter than 4 cycles alone -> no pulse.
3. Press during busy: second clean press debounced inside the GAP -> ignored, step_count stays 1, PCclk single pulse. Press after a release and after the FSM returns to IDLE -> second pulse, step_count=2.
4. Free-run: run_en=1 for 130 cycles -> pulses every 26 cycles, 5 high each, button presses ignored. Drop run_en mid-pulse -> that pulse completes 5 cycles and the gap completes, then no further pulses.
5. Wrap: 64 steps via run_en -> step_count returns 63->0.
6. Reset mid-operation: rst=1 on cycle 2 of PULSE -> PCclk=0, busy=0, step_count=0 after that edge. After rst drops, a new press yields a normal pulse with step_count=1.
